// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that registers one command per cycle onto a single-port synchronous memory.
// Define ARB_STATS_EN to add saturating per-port grant counters (a_count, b_count).
module mem_arbiter #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12,
  parameter int STATW  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [DWIDTH-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [DWIDTH-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic              mem_load,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_d,
  input  logic [DWIDTH-1:0] mem_q,
  output logic [DWIDTH-1:0] rdata
`ifdef ARB_STATS_EN
  ,
  output logic [STATW-1:0]  a_count,
  output logic [STATW-1:0]  b_count
`endif
);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  port_t             r_lastGnt;
  logic              r_s1Valid;
  port_t             r_s1Port;
  logic              r_s2Valid;
  port_t             r_s2Port;

  logic              w_aGnt;
  logic              w_bGnt;
  logic              w_xfer;
  logic              w_selWe;
  logic [AWIDTH-1:0] w_selAddr;
  logic [DWIDTH-1:0] w_selWdata;
  port_t             w_selPort;

  // On contention the port not granted last wins; a lone requester always wins.
  always_comb begin
    w_aGnt     = a_req && (!b_req || (r_lastGnt == PORT_B));
    w_bGnt     = b_req && (!a_req || (r_lastGnt == PORT_A));
    w_xfer     = w_aGnt || w_bGnt;
    w_selPort  = w_aGnt ? PORT_A : PORT_B;
    w_selWe    = w_aGnt ? a_we : b_we;
    w_selAddr  = w_aGnt ? a_addr : b_addr;
    w_selWdata = w_aGnt ? a_wdata : b_wdata;
  end

  assign a_gnt = w_aGnt;
  assign b_gnt = w_bGnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lastGnt <= PORT_B;
      mem_load  <= 1'b0;
      mem_addr  <= '0;
      mem_d     <= '0;
      r_s1Valid <= 1'b0;
      r_s1Port  <= PORT_A;
      r_s2Valid <= 1'b0;
      r_s2Port  <= PORT_A;
    end else begin
      if (w_xfer) begin
        r_lastGnt <= w_selPort;
        mem_load  <= w_selWe;
        mem_addr  <= w_selAddr;
        mem_d     <= w_selWdata;
      end else begin
        mem_load  <= 1'b0;
      end
      // Stage 2 lines up with the memory's registered read data.
      r_s1Valid <= w_xfer && !w_selWe;
      r_s1Port  <= w_selPort;
      r_s2Valid <= r_s1Valid;
      r_s2Port  <= r_s1Port;
    end
  end

  assign rdata    = mem_q;
  assign a_rvalid = r_s2Valid && (r_s2Port == PORT_A);
  assign b_rvalid = r_s2Valid && (r_s2Port == PORT_B);

`ifdef ARB_STATS_EN
  localparam logic [STATW-1:0] STAT_ONE = {{(STATW-1){1'b0}}, 1'b1};

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_count <= '0;
      b_count <= '0;
    end else begin
      if (w_aGnt && (a_count != {STATW{1'b1}})) a_count <= a_count + STAT_ONE;
      if (w_bGnt && (b_count != {STATW{1'b1}})) b_count <= b_count + STAT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 1-cycle synchronous memory.
// Counter checks are compiled in only when ARB_STATS_EN is defined.
module tb_mem_arbiter;

  localparam int DW = 16;
  localparam int AW = 12;

  logic          clk;
  logic          reset;
  logic          aReq, aWe, bReq, bWe;
  logic [AW-1:0] aAddr, bAddr;
  logic [DW-1:0] aWdata, bWdata;
  logic          aGnt, bGnt, aRvalid, bRvalid;
  logic          memLoad;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memD, memQ, rdata;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int compareCount;
  int mismatchCount;

`ifdef ARB_STATS_EN
  logic [15:0]   aCount, bCount;
  logic [1:0]    aCountS, bCountS;
  logic          sGntA, sGntB, sRvA, sRvB, sLoad;
  logic [AW-1:0] sAddr;
  logic [DW-1:0] sD, sRdata;
`endif

  mem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .STATW(16)) dut (
    .clk(clk), .reset(reset),
    .a_req(aReq), .a_we(aWe), .a_addr(aAddr), .a_wdata(aWdata),
    .a_gnt(aGnt), .a_rvalid(aRvalid),
    .b_req(bReq), .b_we(bWe), .b_addr(bAddr), .b_wdata(bWdata),
    .b_gnt(bGnt), .b_rvalid(bRvalid),
    .mem_load(memLoad), .mem_addr(memAddr), .mem_d(memD),
    .mem_q(memQ), .rdata(rdata)
`ifdef ARB_STATS_EN
    , .a_count(aCount), .b_count(bCount)
`endif
  );

`ifdef ARB_STATS_EN
  mem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .STATW(2)) dutSmall (
    .clk(clk), .reset(reset),
    .a_req(aReq), .a_we(aWe), .a_addr(aAddr), .a_wdata(aWdata),
    .a_gnt(sGntA), .a_rvalid(sRvA),
    .b_req(bReq), .b_we(bWe), .b_addr(bAddr), .b_wdata(bWdata),
    .b_gnt(sGntB), .b_rvalid(sRvB),
    .mem_load(sLoad), .mem_addr(sAddr), .mem_d(sD),
    .mem_q(memQ), .rdata(sRdata),
    .a_count(aCountS), .b_count(bCountS)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory with a registered read.
  always @(posedge clk) begin
    if (memLoad) mem[memAddr] <= memD;
    memQ <= mem[memAddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                               input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    aReq = ar; aWe = aw; aAddr = aa; aWdata = ad;
    bReq = br; bWe = bw; bAddr = ba; bWdata = bd;
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
    reset = 1'b0;
    idle();
    step();
    checkOutput("rst_load", memLoad, 0);
    checkOutput("rst_addr", memAddr, 0);
    checkOutput("rst_d", memD, 0);
    checkOutput("rst_arv", aRvalid, 0);
    checkOutput("rst_brv", bRvalid, 0);
    step();
    reset = 1'b1;

    // Single read from A.
    applyStimulus(1, 0, 12'h005, '0, 0, 0, '0, '0);
    checkOutput("t1_agnt", aGnt, 1);
    checkOutput("t1_bgnt", bGnt, 0);
    step();
    idle();
    checkOutput("t1_load", memLoad, 0);
    checkOutput("t1_addr", memAddr, 12'h005);
    checkOutput("t1_arv_e1", aRvalid, 0);
    step();
    checkOutput("t1_arv", aRvalid, 1);
    checkOutput("t1_rdata", rdata, 16'h0005);
    checkOutput("t1_brv", bRvalid, 0);
    step();
    checkOutput("t1_arv_off", aRvalid, 0);

    // Continuous contention right after reset: strict alternation starting with A.
    pulseReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 12'h010, '0, 1, 0, 12'h020, '0);
      checkOutput("t2_agnt", aGnt, (i % 2 == 0));
      checkOutput("t2_bgnt", bGnt, (i % 2 == 1));
      step();
      if (i >= 1) begin
        checkOutput("t2_arv", aRvalid, ((i - 1) % 2 == 0));
        checkOutput("t2_brv", bRvalid, ((i - 1) % 2 == 1));
        checkOutput("t2_rdata", rdata, ((i - 1) % 2 == 0) ? 16'h0010 : 16'h0020);
      end
    end
    idle();
    step();
    checkOutput("t2_brv_last", bRvalid, 1);
    checkOutput("t2_rdata_last", rdata, 16'h0020);
    step();
    checkOutput("t2_arv_end", aRvalid, 0);
    checkOutput("t2_brv_end", bRvalid, 0);

    // B writes, A reads the same address on the next cycle.
    applyStimulus(0, 0, '0, '0, 1, 1, 12'h030, 16'h0ABC);
    checkOutput("t3_bgnt", bGnt, 1);
    step();
    checkOutput("t3_load", memLoad, 1);
    checkOutput("t3_addr", memAddr, 12'h030);
    checkOutput("t3_d", memD, 16'h0ABC);
    applyStimulus(1, 0, 12'h030, '0, 0, 0, '0, '0);
    checkOutput("t3_agnt", aGnt, 1);
    step();
    idle();
    checkOutput("t3_brv_wr", bRvalid, 0);
    checkOutput("t3_arv_early", aRvalid, 0);
    step();
    checkOutput("t3_arv", aRvalid, 1);
    checkOutput("t3_rdata", rdata, 16'h0ABC);
    checkOutput("t3_brv", bRvalid, 0);
    step();

    // Reset lands between acceptance and data return.
    applyStimulus(1, 0, 12'h007, '0, 0, 0, '0, '0);
    step();
    idle();
    checkOutput("t4_addr_pre", memAddr, 12'h007);
    reset = 1'b0;
    #1;
    checkOutput("t4_load", memLoad, 0);
    checkOutput("t4_addr", memAddr, 0);
    checkOutput("t4_d", memD, 0);
    step();
    checkOutput("t4_arv_rst", aRvalid, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("t4_arv", aRvalid, 0);
      checkOutput("t4_brv", bRvalid, 0);
    end

    // B alone three times, then contention: A wins first because the pointer is at B.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, '0, '0, 1, 0, 12'h040, '0);
      checkOutput("t5_bonly_gnt", bGnt, 1);
      checkOutput("t5_bonly_agnt", aGnt, 0);
      step();
    end
    applyStimulus(1, 0, 12'h041, '0, 1, 0, 12'h040, '0);
    checkOutput("t5_both_agnt", aGnt, 1);
    checkOutput("t5_both_bgnt", bGnt, 0);
    step();
    checkOutput("t5_both2_bgnt", bGnt, 1);
    checkOutput("t5_both2_agnt", aGnt, 0);
    step();
    idle();
    step();
    step();

`ifdef ARB_STATS_EN
    // Two A-only grants then six contended grants (B,A,B,A,B,A): A=5, B=3.
    pulseReset();
    checkOutput("st_a0", aCount, 0);
    checkOutput("st_b0", bCount, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 12'h001, '0, 0, 0, '0, '0);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 12'h001, '0, 1, 0, 12'h002, '0);
      step();
    end
    idle();
    step();
    checkOutput("st_a5", aCount, 5);
    checkOutput("st_b3", bCount, 3);
    checkOutput("st_sat_a", aCountS, 3);
    checkOutput("st_sat_b", bCountS, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter in front of the single-port synchronous memory (DWIDTH x WORDS, 1-cycle registered read, write-enable `load`).
- Port A is the instruction-fetch side driven by the FETCH/EXEC sequencer; port B is the loader/debug side.
- The arbiter accepts at most one command per cycle and registers it onto the memory interface.
- It returns read data with a per-port valid pulse.

Parameters:
- DWIDTH, 16, data width.
- AWIDTH, 12, address width.
- STATW, 16, width of grant counters (optional feature only).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- a_req  input  1  port A command valid.
- a_we  input  1  port A write (1) / read (0).
- a_addr  input  AWIDTH  port A address.
- a_wdata  input  DWIDTH  port A write data.
- a_gnt  output  1  port A command accepted this cycle (combinational).
- a_rvalid  output  1  port A read data valid on rdata.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid: same as port A, for port B.
- mem_load  output  1  memory write enable (registered).
- mem_addr  output  AWIDTH  memory address (registered).
- mem_d  output  DWIDTH  memory write data (registered).
- mem_q  input  DWIDTH  memory read data.
- rdata  output  DWIDTH  read data, equal to mem_q.
- a_count, b_count  output  STATW  grant counters (only when ARB_STATS_EN is defined).

Behaviour:
- Reset (async, active-low):
  - mem_load=0, mem_addr=0, mem_d=0.
  - a_rvalid=b_rvalid=0; read pipeline flags cleared.
  - last-grant pointer = B, so A wins the first contention.
- Handshake is valid/ready style. A transfer occurs at a rising edge where req && gnt. The requester holds req and its command stable until that edge.
- Grant (combinational; at most one gnt high per cycle):
  - Only A requesting -> a_gnt. Only B requesting -> b_gnt.
  - Both requesting -> grant the port that was not granted last.
  - Neither requesting -> no gnt.
- Pointer update: on each transfer edge the pointer records the granted port. It is unchanged on idle cycles.
- Issue edge E1 (transfer):
  - mem_addr <= sel_addr; mem_d <= sel_wdata; mem_load <= sel_we.
  - Read pipeline flag stage 1 <= (read, port id).
- Idle edge: mem_load <= 0; mem_addr and mem_d hold their values; stage-1 flag <= none.
- Edge E2: the memory captures the command. The stage-1 flag moves to stage 2. x_rvalid is driven from stage 2, so it is high for exactly one cycle after E2, with rdata = mem_q.
- Read latency: the request is accepted at E1 and data is valid in the cycle after E2 (2 edges). This sustains 1 read per cycle with back-to-back grants.
- Writes:
  - Never produce rvalid.
  - A read of the same address accepted in the cycle after a write returns the new data, because the memory write lands at E2 before the read samples at E3.
- Round-robin fairness: under continuous requests from both ports, grants strictly alternate. No port waits more than 1 cycle.
- Reset mid-operation clears in-flight reads. No rvalid appears after reset is released until a new read is accepted.
- Requests held during reset are evaluated normally on the first edge after release. Port A wins if both are requesting.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - a_count and b_count ports exist; reset to 0.
  - Each increments by 1 on every transfer edge for its port.
  - Each saturates at all-ones; no wrap.
- Not defined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Memory preloaded with mem[i]=i. A reads 0x005 alone -> a_gnt high in the same cycle; mem_load=0, mem_addr=0x005 after E1; a_rvalid=1 with rdata=0x0005 in the cycle after E2; b_rvalid stays 0.
- A (addr 0x010) and B (addr 0x020) both request continuously for 6 cycles, first cycle after reset -> grant order A,B,A,B,A,B; rvalid/rdata sequence 0x0010(A), 0x0020(B), alternating.
- B writes 0x0ABC to 0x030, then A reads 0x030 in the next cycle -> no rvalid for the write; a_rvalid with rdata=0x0ABC.
- A read is accepted, then reset is pulsed low before E2 -> a_rvalid never asserts; mem_load/mem_addr/mem_d are 0 after reset.
- Only B requests for 3 cycles, then both request -> B is granted 3 times, then A is granted first (pointer=B); no idle cycle between grants.
- With ARB_STATS_EN: 5 A grants and 3 B grants -> a_count=5, b_count=3. With STATW=2 and 5 grants -> count stays 3.
